boid_frame_renderer: RTL and testbench

- Double-buffered 1-bit boid framebuffer that sits directly upstream of the VGA controller.
- Each frame it clears the back bank, then plots every boid as a BOID_SIZE x BOID_SIZE white square. Positions are fetched from the boid position memory.
- It serves the VGA controller's pixel read port (boid_read_address / boid_read_data) from the front bank.
- Banks swap on the VGA screen_end pulse, so the display never tears.

---
 rtl/boid_frame_renderer.sv | 188 ++++++++++++++++++
 tb/tb_boid_frame_renderer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/boid_frame_renderer.sv
// Double-buffered 1-bit boid framebuffer: clears the back bank, plots each boid as a square,
// and serves VGA pixel reads from the front bank. Optional macro BOID_RENDER_STATS_EN enables overrun_count.
module boid_frame_renderer #(
  parameter int unsigned VIDEO_WIDTH         = 640,
  parameter int unsigned VIDEO_HEIGHT        = 480,
  parameter int unsigned PIXEL_ADDRESS_WIDTH = 20,
  parameter int unsigned NUM_BOIDS           = 32,
  parameter int unsigned BOID_IDX_WIDTH      = 5,
  parameter int unsigned BOID_SIZE           = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           screen_end,
  input  logic [PIXEL_ADDRESS_WIDTH-1:0] boid_read_address,
  output logic                           boid_read_data,
  output logic [BOID_IDX_WIDTH-1:0]      boid_idx,
  input  logic [9:0]                     boid_x,
  input  logic [8:0]                     boid_y,
  output logic                           busy,
  output logic                           frame_swap,
  output logic [7:0]                     overrun_count
);

  localparam int unsigned NPIX = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int unsigned PAW  = PIXEL_ADDRESS_WIDTH;
  localparam int unsigned MAW  = PIXEL_ADDRESS_WIDTH + 1;
  localparam int unsigned CW   = 11;
  localparam int unsigned DW   = (BOID_SIZE > 1) ? $clog2(BOID_SIZE) : 1;
  localparam int unsigned IW   = BOID_IDX_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_LATCH, S_DRAW} state_e;

  state_e         state_q;
  logic           front_q;
  logic           display_valid_q;
  logic           rendered_q;
  logic           se_prev_q;
  logic [PAW-1:0] clr_addr_q;
  logic [9:0]     bx_q;
  logic [8:0]     by_q;
  logic [DW-1:0]  dx_q;
  logic [DW-1:0]  dy_q;

  logic           mem_q [0:2*NPIX-1];

  logic           event_c;
  logic [CW-1:0]  px_c;
  logic [CW-1:0]  py_c;
  logic           in_range_c;
  logic [PAW-1:0] draw_addr_c;
  logic           last_dx_c;
  logic           last_dy_c;
  logic           we_c;
  logic           wdata_c;
  logic [PAW-1:0] waddr_c;
  logic [MAW-1:0] wr_index_c;
  logic [MAW-1:0] rd_index_c;

  assign event_c = screen_end & ~se_prev_q;

  // 11-bit sums so pixels past the right edge are clipped rather than wrapping into the next row
  assign px_c        = CW'(bx_q) + CW'(dx_q);
  assign py_c        = CW'(by_q) + CW'(dy_q);
  assign in_range_c  = (px_c < CW'(VIDEO_WIDTH)) && (py_c < CW'(VIDEO_HEIGHT));
  assign draw_addr_c = PAW'(px_c) + PAW'(VIDEO_WIDTH) * PAW'(py_c);
  assign last_dx_c   = (dx_q == DW'(BOID_SIZE - 1));
  assign last_dy_c   = (dy_q == DW'(BOID_SIZE - 1));

  // Write port always targets the back bank
  always_comb begin
    we_c    = 1'b0;
    wdata_c = 1'b0;
    waddr_c = clr_addr_q;
    case (state_q)
      S_CLEAR: we_c = 1'b1;
      S_DRAW: begin
        we_c    = in_range_c;
        wdata_c = 1'b1;
        waddr_c = draw_addr_c;
      end
      default: ;
    endcase
  end

  assign wr_index_c = (front_q ? MAW'(0) : MAW'(NPIX)) + MAW'(waddr_c);
  assign rd_index_c = (front_q ? MAW'(NPIX) : MAW'(0)) + MAW'(boid_read_address);

  always_ff @(posedge clk) begin
    if (we_c) mem_q[wr_index_c] <= wdata_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      boid_read_data <= 1'b0;
    end else begin
      boid_read_data <= (display_valid_q && (boid_read_address < PAW'(NPIX))) ?
                        mem_q[rd_index_c] : 1'b0;
    end
  end

  // Render sequencer: IDLE -> CLEAR -> (FETCH -> LATCH -> DRAW) per boid -> IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      front_q         <= 1'b0;
      display_valid_q <= 1'b0;
      rendered_q      <= 1'b0;
      se_prev_q       <= 1'b0;
      busy            <= 1'b0;
      frame_swap      <= 1'b0;
      boid_idx        <= '0;
      clr_addr_q      <= '0;
      bx_q            <= '0;
      by_q            <= '0;
      dx_q            <= '0;
      dy_q            <= '0;
    end else begin
      se_prev_q  <= screen_end;
      frame_swap <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (event_c) begin
            if (rendered_q) begin
              front_q         <= ~front_q;
              display_valid_q <= 1'b1;
              frame_swap      <= 1'b1;
            end
            rendered_q <= 1'b0;
            busy       <= 1'b1;
            clr_addr_q <= '0;
            state_q    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + PAW'(1);
          if (clr_addr_q == PAW'(NPIX - 1)) begin
            boid_idx <= '0;
            state_q  <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          bx_q    <= boid_x;
          by_q    <= boid_y;
          dx_q    <= '0;
          dy_q    <= '0;
          state_q <= S_DRAW;
        end
        S_DRAW: begin
          if (!last_dx_c) begin
            dx_q <= dx_q + DW'(1);
          end else begin
            dx_q <= '0;
            if (!last_dy_c) begin
              dy_q <= dy_q + DW'(1);
            end else if (boid_idx == IW'(NUM_BOIDS - 1)) begin
              rendered_q <= 1'b1;
              busy       <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              boid_idx <= boid_idx + IW'(1);
              state_q  <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef BOID_RENDER_STATS_EN
  logic [7:0] overrun_q;

  // Frames dropped because a new frame boundary arrived mid-render
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 8'd0;
    end else if (event_c && busy && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign overrun_count = overrun_q;
`else
  assign overrun_count = 8'd0;
`endif

endmodule

// File: tb/tb_boid_frame_renderer.sv
// Directed bench for boid_frame_renderer on a reduced 64x48 screen with one 2x2 boid.
module tb_boid_frame_renderer;

  localparam int unsigned W    = 64;
  localparam int unsigned H    = 48;
  localparam int unsigned NPIX = W * H;
  localparam int unsigned PAW  = 12;

  logic           clk;
  logic           reset;
  logic           screen_end;
  logic [PAW-1:0] boid_read_address;
  logic           boid_read_data;
  logic [0:0]     boid_idx;
  logic [9:0]     boid_x;
  logic [8:0]     boid_y;
  logic           busy;
  logic           frame_swap;
  logic [7:0]     overrun_count;

  int n_checks;
  int n_errors;
  int swap_cnt;
  int busy_run;
  int last_len;
  int s0;
  int exp_ovr;

  boid_frame_renderer #(
    .VIDEO_WIDTH(W), .VIDEO_HEIGHT(H), .PIXEL_ADDRESS_WIDTH(PAW),
    .NUM_BOIDS(1), .BOID_IDX_WIDTH(1), .BOID_SIZE(2)
  ) dut (
    .clk(clk), .reset(reset), .screen_end(screen_end),
    .boid_read_address(boid_read_address), .boid_read_data(boid_read_data),
    .boid_idx(boid_idx), .boid_x(boid_x), .boid_y(boid_y),
    .busy(busy), .frame_swap(frame_swap), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  // Observe swap pulses and busy run length on the inactive edge
  always @(negedge clk) begin
    if (frame_swap === 1'b1) swap_cnt++;
    if (busy === 1'b1) busy_run++;
    else begin
      if (busy_run != 0) last_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_event();
    @(negedge clk) screen_end = 1'b1;
    repeat (4) @(negedge clk);
    screen_end = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int budget, input string tag);
    int n = 0;
    while (busy !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(busy), 32'(val));
  endtask

  task automatic frame(input int bx, input int by);
    boid_x = 10'(bx);
    boid_y = 9'(by);
    pulse_event();
    wait_busy(1'b1, 20, "busy_rise");
    wait_busy(1'b0, NPIX + 100, "busy_fall");
    @(negedge clk);
  endtask

  task automatic read_px(input int addr, input logic exp, input string tag);
    @(negedge clk) boid_read_address = PAW'(addr);
    @(posedge clk);
    #1 check_eq(tag, 32'(boid_read_data), 32'(exp));
  endtask

  initial begin
    n_checks = 0; n_errors = 0; swap_cnt = 0; busy_run = 0; last_len = 0;
    clk = 1'b0; reset = 1'b0; screen_end = 1'b0;
    boid_read_address = '0; boid_x = '0; boid_y = '0;
`ifdef BOID_RENDER_STATS_EN
    exp_ovr = 1;
`else
    exp_ovr = 0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;

    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_swap", 32'(frame_swap), 0);
    check_eq("rst_idx", 32'(boid_idx), 0);
    check_eq("rst_ovr", 32'(overrun_count), 0);
    read_px(0, 1'b0, "rst_rd0");
    read_px(1290, 1'b0, "rst_rd1290");
    read_px(NPIX - 1, 1'b0, "rst_rdlast");

    // First frame: no swap, nothing displayed yet
    s0 = swap_cnt;
    frame(10, 20);
    check_eq("f1_swaps", 32'(swap_cnt - s0), 0);
    check_eq("f1_len", 32'(last_len), 32'(NPIX + 6));
    read_px(1290, 1'b0, "f1_invalid_rd");

    // Second event swaps in the (10,20) render
    s0 = swap_cnt;
    frame(10, 20);
    check_eq("f2_swaps", 32'(swap_cnt - s0), 1);
    read_px(1290, 1'b1, "sq_1290");
    read_px(1291, 1'b1, "sq_1291");
    read_px(1354, 1'b1, "sq_1354");
    read_px(1355, 1'b1, "sq_1355");
    read_px(1292, 1'b0, "sq_1292");
    read_px(1289, 1'b0, "sq_1289");
    // Latency: data still reflects the old address until the next edge
    @(negedge clk) boid_read_address = PAW'(1290);
    #1 check_eq("lat_before", 32'(boid_read_data), 0);
    @(posedge clk);
    #1 check_eq("lat_after", 32'(boid_read_data), 1);

    // Bottom-right corner boid, clipped to one pixel
    s0 = swap_cnt;
    frame(63, 47);
    check_eq("f3_swaps", 32'(swap_cnt - s0), 1);
    check_eq("corner_len", 32'(last_len), 32'(NPIX + 6));
    frame(40, 30);
    read_px(3071, 1'b1, "corner_3071");
    read_px(3070, 1'b0, "corner_3070");
    read_px(3007, 1'b0, "corner_3007");
    read_px(3008, 1'b0, "corner_noalias");
    read_px(0, 1'b0, "corner_0");
    read_px(1290, 1'b0, "corner_old");
    read_px(3072, 1'b0, "oob_3072");
    read_px(4095, 1'b0, "oob_4095");

    // Moved boid; stale content in the reused bank must be gone
    frame(40, 30);
    read_px(1960, 1'b1, "mv_1960");
    read_px(1961, 1'b1, "mv_1961");
    read_px(2024, 1'b1, "mv_2024");
    read_px(2025, 1'b1, "mv_2025");
    read_px(1959, 1'b0, "mv_1959");
    read_px(3071, 1'b0, "mv_stale_corner");
    read_px(1290, 1'b0, "mv_stale_old");

    // Overrun: second event during CLEAR
    pulse_event();
    wait_busy(1'b1, 20, "ovr_busy_rise");
    repeat (1000) @(negedge clk);
    s0 = swap_cnt;
    pulse_event();
    repeat (3) @(negedge clk);
    check_eq("ovr_swaps", 32'(swap_cnt - s0), 0);
    check_eq("ovr_count", 32'(overrun_count), 32'(exp_ovr));
    check_eq("ovr_busy", 32'(busy), 1);

    // Reset during DRAW
    begin
      int n = 0;
      while (busy_run < int'(NPIX + 4) && n < int'(NPIX + 50)) begin
        @(negedge clk);
        #1 n++;
      end
      check_eq("reach_draw", 32'(busy_run >= int'(NPIX + 4)), 1);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_ovr", 32'(overrun_count), 0);
    check_eq("mid_rst_idx", 32'(boid_idx), 0);
    read_px(1960, 1'b0, "mid_rst_rd");
    s0 = swap_cnt;
    frame(40, 30);
    check_eq("post_rst_swaps", 32'(swap_cnt - s0), 0);
    read_px(1960, 1'b0, "post_rst_rd");
    s0 = swap_cnt;
    frame(40, 30);
    check_eq("post_rst_swap2", 32'(swap_cnt - s0), 1);
    read_px(1960, 1'b1, "post_rst_show");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
